// File: rtl/mac_dot_engine.sv
// Multi-lane multiply-accumulate dot-product engine: LANES products per beat, summed and
// accumulated over cfg_len beats, presented on a valid/ready result port, then auto-cleared.
module mac_dot_engine #(
    parameter int A_W      = 8,
    parameter int B_W      = 8,
    parameter int LANES    = 4,
    parameter int ACC_W    = 32,
    parameter int LEN_W    = 16,
    parameter int SATURATE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LEN_W-1:0]     cfg_len,
    input  logic                 cfg_signed,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*A_W-1:0] in_a,
    input  logic [LANES*B_W-1:0] in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     out_acc,
    output logic                 out_ovf,
    output logic [1:0]           dbg_state
);
    // Handshake: a beat moves on a rising edge with in_valid && in_ready; a result moves on a
    // rising edge with out_valid && out_ready. Neither ready depends combinationally on valid.

    localparam int P_W = A_W + B_W;
    localparam int S_W = ACC_W + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t               state, state_nx;
    logic                 ready_q, ready_nx;
    logic [LEN_W-1:0]     len_q, cnt_q, len_first;
    logic                 signed_q, mode_now, beat, out_fire;
    logic [LANES*P_W-1:0] prod_nx, prod_q;
    logic                 prod_valid;
    logic [ACC_W-1:0]     acc_q, acc_nx;
    logic                 ovf_q, ovf_now;
    logic [S_W-1:0]       lane_sum, wide;

    assign beat      = in_valid && ready_q;
    assign out_fire  = (state == HOLD) && out_ready;
    assign len_first = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
    // The first beat is multiplied in the same cycle its mode is latched.
    assign mode_now  = (state == IDLE) ? cfg_signed : signed_q;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (beat) state_nx = (len_first == LEN_W'(1)) ? DRAIN : ACCUM;
            ACCUM:   if (beat && (cnt_q == len_q - LEN_W'(1))) state_nx = DRAIN;
            DRAIN:   state_nx = HOLD;
            HOLD:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // Ready only reopens one cycle after arriving back in IDLE (no bypass from HOLD).
        ready_nx = ((state == IDLE) || (state == ACCUM)) &&
                   ((state_nx == IDLE) || (state_nx == ACCUM));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ready_q <= 1'b1;
        end else begin
            state   <= state_nx;
            ready_q <= ready_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q    <= '0;
            cnt_q    <= '0;
            signed_q <= 1'b0;
        end else if (beat) begin
            if (state == IDLE) begin
                len_q    <= len_first;
                signed_q <= cfg_signed;
                cnt_q    <= LEN_W'(1);
            end else begin
                cnt_q <= cnt_q + LEN_W'(1);
            end
        end
    end

    always_comb begin
        logic [P_W-1:0] a_ext;
        logic [P_W-1:0] b_ext;
        prod_nx = '0;
        a_ext   = '0;
        b_ext   = '0;
        for (int i = 0; i < LANES; i++) begin
            a_ext = {{B_W{mode_now & in_a[i*A_W+A_W-1]}}, in_a[i*A_W +: A_W]};
            b_ext = {{A_W{mode_now & in_b[i*B_W+B_W-1]}}, in_b[i*B_W +: B_W]};
            // Low P_W bits of the extended product are exact in both modes.
            prod_nx[i*P_W +: P_W] = a_ext * b_ext;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_q     <= '0;
            prod_valid <= 1'b0;
        end else begin
            prod_valid <= beat;
            if (beat) prod_q <= prod_nx;
        end
    end

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum +
                {{(S_W-P_W){signed_q & prod_q[i*P_W+P_W-1]}}, prod_q[i*P_W +: P_W]};
        end
        wide    = lane_sum + {{2{acc_q[ACC_W-1]}}, acc_q};
        // In range only when the top three bits agree.
        ovf_now = !((wide[S_W-1:ACC_W-1] == '0) || (wide[S_W-1:ACC_W-1] == '1));
        acc_nx  = wide[ACC_W-1:0];
        if (ovf_now && (SATURATE != 0)) begin
            acc_nx = wide[S_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (out_fire) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (prod_valid) begin
            acc_q <= acc_nx;
            ovf_q <= ovf_q | ovf_now;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = (state == HOLD);
    assign out_acc   = acc_q;
    assign out_ovf   = ovf_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_mac_dot_engine.sv
// Directed bench for mac_dot_engine: a 32-bit saturating engine plus 18-bit saturating and
// wrapping engines driven by the same stimulus.
module tb_mac_dot_engine;

    logic        clk;
    logic        rst;
    logic [15:0] cfg_len;
    logic        cfg_signed;
    logic        in_valid;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_ready;

    logic        in_ready, out_valid, out_ovf;
    logic [31:0] out_acc;
    logic [1:0]  dbg_state;
    logic        s_in_ready, s_out_valid, s_out_ovf;
    logic [17:0] s_out_acc;
    logic [1:0]  s_dbg_state;
    logic        w_in_ready, w_out_valid, w_out_ovf;
    logic [17:0] w_out_acc;
    logic [1:0]  w_dbg_state;

    int errors = 0;
    int checks = 0;

    mac_dot_engine u_dut (
        .clk(clk), .rst(rst), .cfg_len(cfg_len), .cfg_signed(cfg_signed),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
        .out_ovf(out_ovf), .dbg_state(dbg_state)
    );

    mac_dot_engine #(.ACC_W(18), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .cfg_len(cfg_len), .cfg_signed(cfg_signed),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_acc(s_out_acc),
        .out_ovf(s_out_ovf), .dbg_state(s_dbg_state)
    );

    mac_dot_engine #(.ACC_W(18), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .cfg_len(cfg_len), .cfg_signed(cfg_signed),
        .in_valid(in_valid), .in_ready(w_in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_acc(w_out_acc),
        .out_ovf(w_out_ovf), .dbg_state(w_dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] len;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_acc;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [31:0] pack4(input int l0, input int l1, input int l2, input int l3);
        logic [31:0] r;
        r[7:0]   = l0[7:0];
        r[15:8]  = l1[7:0];
        r[23:16] = l2[7:0];
        r[31:24] = l3[7:0];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name,
                     $signed(act), act, $signed(exp), exp);
        end
    endtask

    // Presents one beat and returns #1 after the edge that accepted it.
    task automatic send_beat();
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        for (int w = 0; w < 40; w++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL beat_accept: in_ready stayed 0 for 40 cycles");
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_product(input logic [15:0] len, input logic sgn,
                               input logic [31:0] a, input logic [31:0] b,
                               input int nbeats, input int gap,
                               output logic [31:0] acc, output logic ovf,
                               output logic [17:0] acc_s, output logic ovf_s,
                               output logic [17:0] acc_w, output logic ovf_w,
                               output int lat, output int rdy_low);
        logic seen;
        cfg_len    = len;
        cfg_signed = sgn;
        in_a       = a;
        in_b       = b;
        for (int n = 0; n < nbeats; n++) begin
            send_beat();
            cfg_len    = 16'hffff;
            cfg_signed = ~sgn;
            if (gap > 0 && n != nbeats - 1) begin
                in_valid = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        seen = 1'b0;
        lat = -1;
        rdy_low = 0;
        acc = '0; ovf = 1'b0; acc_s = '0; ovf_s = 1'b0; acc_w = '0; ovf_w = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (out_valid && !seen) begin
                seen  = 1'b1;
                lat   = k;
                acc   = out_acc;   ovf   = out_ovf;
                acc_s = s_out_acc; ovf_s = s_out_ovf;
                acc_w = w_out_acc; ovf_w = w_out_ovf;
            end
            if (!in_ready) rdy_low++;
            if (seen && in_ready) break;
        end
        cfg_len    = 16'd1;
        cfg_signed = 1'b0;
    endtask

    logic [31:0] r_acc;
    logic        r_ovf, r_ovf_s, r_ovf_w;
    logic [17:0] r_acc_s, r_acc_w;
    int          r_lat, r_rdy_low, stable_cnt, valid_seen;

    initial begin
        rst        = 1'b0;
        cfg_len    = 16'd1;
        cfg_signed = 1'b0;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        out_ready  = 1'b1;

        vecs[0] = '{16'd1, 1'b1, pack4(-1, 2, 3, -128), pack4(-128, 5, -7, -128), 32'd16501, 1'b0};
        vecs[1] = '{16'd1, 1'b0, pack4(255, 255, 255, 255), pack4(255, 255, 255, 255), 32'd260100, 1'b0};
        vecs[2] = '{16'd0, 1'b1, pack4(-1, 2, 3, -128), pack4(-128, 5, -7, -128), 32'd16501, 1'b0};
        vecs[3] = '{16'd1, 1'b0, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 32'd70, 1'b0};
        vecs[4] = '{16'd0, 1'b1, pack4(-128, -128, -128, -128), pack4(127, 127, 127, 127), 32'(-65024), 1'b0};
        vecs[5] = '{16'd1, 1'b0, pack4(128, 128, 128, 128), pack4(2, 2, 2, 2), 32'd1024, 1'b0};
        vecs[6] = '{16'd1, 1'b1, pack4(128, 128, 128, 128), pack4(2, 2, 2, 2), 32'(-1024), 1'b0};
        vecs[7] = '{16'd1, 1'b1, pack4(127, -1, 0, 5), pack4(127, -1, 100, -3), 32'd16115, 1'b0};

        repeat (3) @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_acc", out_acc, 32'd0);
        check("reset_out_ovf", 32'(out_ovf), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single-beat products, including cfg_len=0 aliases of cfg_len=1.
        for (int v = 0; v < 8; v++) begin
            run_product(vecs[v].len, vecs[v].sgn, vecs[v].a, vecs[v].b, 1, 0,
                        r_acc, r_ovf, r_acc_s, r_ovf_s, r_acc_w, r_ovf_w, r_lat, r_rdy_low);
            check($sformatf("vec%0d_acc", v), r_acc, vecs[v].exp_acc);
            check($sformatf("vec%0d_ovf", v), 32'(r_ovf), 32'(vecs[v].exp_ovf));
            check($sformatf("vec%0d_latency", v), 32'(r_lat), 32'd2);
        end

        // Three gapless unsigned beats of all-255 lanes.
        run_product(16'd3, 1'b0, pack4(255, 255, 255, 255), pack4(255, 255, 255, 255), 3, 0,
                    r_acc, r_ovf, r_acc_s, r_ovf_s, r_acc_w, r_ovf_w, r_lat, r_rdy_low);
        check("len3_unsigned_acc", r_acc, 32'd780300);
        check("len3_unsigned_latency", 32'(r_lat), 32'd2);
        check("len3_ready_low_cycles", 32'(r_rdy_low), 32'd3);

        // Overflow on the 18-bit engines: each beat adds 65536.
        run_product(16'd4, 1'b1, pack4(-128, -128, -128, -128), pack4(-128, -128, -128, -128), 4, 0,
                    r_acc, r_ovf, r_acc_s, r_ovf_s, r_acc_w, r_ovf_w, r_lat, r_rdy_low);
        check("ovf_wide_acc", r_acc, 32'd262144);
        check("ovf_wide_ovf", 32'(r_ovf), 32'd0);
        check("ovf_sat_acc", {14'd0, r_acc_s}, 32'd131071);
        check("ovf_sat_ovf", 32'(r_ovf_s), 32'd1);
        check("ovf_wrap_acc", {14'd0, r_acc_w}, 32'd0);
        check("ovf_wrap_ovf", 32'(r_ovf_w), 32'd1);

        // Sticky flag must not leak into the next product.
        run_product(16'd1, 1'b0, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 1, 0,
                    r_acc, r_ovf, r_acc_s, r_ovf_s, r_acc_w, r_ovf_w, r_lat, r_rdy_low);
        check("after_ovf_sat_acc", {14'd0, r_acc_s}, 32'd4);
        check("after_ovf_sat_ovf", 32'(r_ovf_s), 32'd0);
        check("after_ovf_wrap_ovf", 32'(r_ovf_w), 32'd0);

        // Gapped and gapless beats must agree.
        run_product(16'd3, 1'b1, pack4(-5, -5, -5, -5), pack4(7, 7, 7, 7), 3, 2,
                    r_acc, r_ovf, r_acc_s, r_ovf_s, r_acc_w, r_ovf_w, r_lat, r_rdy_low);
        check("gapped_acc", r_acc, 32'(-420));
        check("gapped_latency", 32'(r_lat), 32'd2);
        run_product(16'd3, 1'b1, pack4(-5, -5, -5, -5), pack4(7, 7, 7, 7), 3, 0,
                    r_acc, r_ovf, r_acc_s, r_ovf_s, r_acc_w, r_ovf_w, r_lat, r_rdy_low);
        check("gapless_acc", r_acc, 32'(-420));

        // Back-pressure: result held for 10 cycles with out_ready low.
        out_ready  = 1'b0;
        cfg_len    = 16'd2;
        cfg_signed = 1'b1;
        in_a       = pack4(3, 3, 3, 3);
        in_b       = pack4(-4, -4, -4, -4);
        send_beat();
        send_beat();
        in_valid = 1'b0;
        valid_seen = 0;
        for (int k = 0; k < 20 && valid_seen == 0; k++) begin
            @(negedge clk);
            if (out_valid) valid_seen = 1;
        end
        check("hold_valid_rise", 32'(valid_seen), 32'd1);
        stable_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_acc === 32'(-96) && in_ready === 1'b0) stable_cnt++;
        end
        check("hold_stable_cycles", 32'(stable_cnt), 32'd10);
        check("hold_acc", out_acc, 32'(-96));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hold_release_valid", 32'(out_valid), 32'd0);
        check("hold_release_acc_clear", out_acc, 32'd0);
        check("hold_release_ready", 32'(in_ready), 32'd0);
        run_product(16'd1, 1'b0, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 1, 0,
                    r_acc, r_ovf, r_acc_s, r_ovf_s, r_acc_w, r_ovf_w, r_lat, r_rdy_low);
        check("after_hold_acc", r_acc, 32'd4);

        // Reset during ACCUM aborts the product.
        cfg_len    = 16'd5;
        cfg_signed = 1'b0;
        in_a       = pack4(9, 9, 9, 9);
        in_b       = pack4(9, 9, 9, 9);
        send_beat();
        send_beat();
        in_valid = 1'b0;
        check("abort_state_accum", 32'(dbg_state), 32'd1);
        rst = 1'b0;
        #2;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out_acc", out_acc, 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        valid_seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid) valid_seen++;
        end
        check("abort_no_result", 32'(valid_seen), 32'd0);
        run_product(vecs[7].len, vecs[7].sgn, vecs[7].a, vecs[7].b, 1, 0,
                    r_acc, r_ovf, r_acc_s, r_ovf_s, r_acc_w, r_ovf_w, r_lat, r_rdy_low);
        check("after_abort_acc", r_acc, 32'd16115);
        check("after_abort_latency", 32'(r_lat), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
